// File: rtl/hazard_pkg.sv
// Shared types and constants for the parametrised ARM pipeline hazard unit.
// Forward-select encodings match the Execute-stage operand mux inputs.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } holdoff_state_t;

  // Wide enough for any sane register address; sliced down to AW by users.
  localparam int MAX_AW = 32;
  localparam logic [MAX_AW-1:0] REG_PC = '1;

  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// Datapath-facing bundle of the hazard unit: register addresses and pipeline
// control in, stall/flush/forward controls and event counters out.
interface hazard_ctrl_param_if #(
  parameter int NRP   = 3,
  parameter int AW    = 4,
  parameter int CNT_W = 16
);

  logic [NRP*AW-1:0] ra_d;
  logic [NRP-1:0]    ra_d_used;
  logic [NRP*AW-1:0] ra_e;
  logic [NRP-1:0]    ra_e_used;
  logic [AW-1:0]     wa_e;
  logic [AW-1:0]     wa_m;
  logic [AW-1:0]     wa_w;
  logic              regwrite_e;
  logic              regwrite_m;
  logic              regwrite_w;
  logic              memtoreg_e;
  logic              pcsrc_d;
  logic              pcsrc_e;
  logic              pcsrc_m;
  logic              pcsrc_w;
  logic              branch_taken_e;
  logic              cnt_clr;

  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [2*NRP-1:0]  fwd_sel_e;
  logic              holdoff_active;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ra_d, ra_d_used, ra_e, ra_e_used,
    output wa_e, wa_m, wa_w,
    output regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
    output pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, cnt_clr,
    input  stall_f, stall_d, flush_d, flush_e, fwd_sel_e,
    input  holdoff_active, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra_d, ra_d_used, ra_e, ra_e_used,
    input  wa_e, wa_m, wa_w,
    input  regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
    input  pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, cnt_clr,
    output stall_f, stall_d, flush_d, flush_e, fwd_sel_e,
    output holdoff_active, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_param_holdoff.sv
// Post-reset holdoff FSM: stays in HOLD for HOLDOFF clock edges after reset
// release, then moves to RUN until the next reset.
module hazard_holdoff
  import hazard_pkg::*;
#(
  parameter int HOLDOFF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic holdoff_active
);

  localparam int CW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  holdoff_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_edge;

  // HOLDOFF of 0 or 1 both leave HOLD on the first edge after release.
  assign last_edge = (HOLDOFF == 0) || (cnt_q == CW'(LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == HOLD) begin
      if (last_edge) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign holdoff_active = (state_q == HOLD);

endmodule

// File: rtl/hazard_ctrl_param.sv
// Parametrised hazard unit for the 5-stage ARM pipeline: NRP-port forwarding,
// load-use and PC-write stalls/flushes, holdoff, saturating event counters.
module hazard_ctrl_param
  import hazard_pkg::*;
#(
  parameter int NRP      = 3,
  parameter int AW       = 4,
  parameter int HOLDOFF  = 4,
  parameter int CNT_W    = 16,
  parameter int EXCL_R15 = 1
) (
  input logic               clk,
  input logic               reset,
  hazard_ctrl_param_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0]    PC_ADDR = REG_PC[AW-1:0];

  logic             holdoff_active;
  logic             run;
  logic [NRP-1:0]   hit_m;
  logic [NRP-1:0]   hit_w;
  logic [NRP-1:0]   hit_ld;
  logic [2*NRP-1:0] fwd_raw;

  logic             ldrstall;
  logic             pcw;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [2*NRP-1:0] fwd_sel;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  hazard_holdoff #(
    .HOLDOFF (HOLDOFF)
  ) u_holdoff (
    .clk            (clk),
    .reset          (reset),
    .holdoff_active (holdoff_active)
  );

  assign run = ~holdoff_active;

  // Per-port comparators; the PC address is never forwarded when excluded
  // because R15 reads come from the PC path, not from a writeback result.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0] ra_e_p;
    logic [AW-1:0] ra_d_p;
    logic          is_pc;

    assign ra_e_p   = hz.ra_e[p*AW +: AW];
    assign ra_d_p   = hz.ra_d[p*AW +: AW];
    assign is_pc    = (EXCL_R15 != 0) && (ra_e_p == PC_ADDR);
    assign hit_m[p] = hz.ra_e_used[p] & hz.regwrite_m & (ra_e_p == hz.wa_m) & ~is_pc;
    assign hit_w[p] = hz.ra_e_used[p] & hz.regwrite_w & (ra_e_p == hz.wa_w) & ~is_pc;
    assign hit_ld[p] = hz.ra_d_used[p] & (ra_d_p == hz.wa_e);
    assign fwd_raw[2*p +: 2] = fwd_pick(hit_m[p], hit_w[p]);
  end

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    fwd_sel  = '0;
    ldrstall = hz.memtoreg_e & hz.regwrite_e & (|hit_ld);
    pcw      = hz.pcsrc_d | hz.pcsrc_e | hz.pcsrc_m;
    if (run) begin
      stall_d = ldrstall;
      stall_f = ldrstall | pcw;
      flush_d = pcw | hz.pcsrc_w | hz.branch_taken_e;
      flush_e = ldrstall | hz.branch_taken_e;
      fwd_sel = fwd_raw;
    end
  end

  // Flush events count once per cycle no matter how many flush lines are up.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run) begin
      if (hz.cnt_clr) begin
        stall_cnt_d = '0;
        flush_cnt_d = '0;
      end else begin
        if (stall_f && (stall_cnt_q != CNT_MAX)) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((flush_d || flush_e) && (flush_cnt_q != CNT_MAX)) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_f        = stall_f;
  assign hz.stall_d        = stall_d;
  assign hz.flush_d        = flush_d;
  assign hz.flush_e        = flush_e;
  assign hz.fwd_sel_e      = fwd_sel;
  assign hz.holdoff_active = holdoff_active;
  assign hz.stall_cnt      = stall_cnt_q;
  assign hz.flush_cnt      = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised successor to the fixed two-port hazard unit of the 5-stage ARM pipeline (F/D/E/M/W).
- Generalises the design to NRP register read ports, so the shifter RA3 port is covered alongside RA1/RA2.
- Also provides:
  - a configurable post-reset hazard holdoff;
  - per-port use masks;
  - optional R15 forwarding exclusion;
  - saturating stall and flush event counters.
- Sits beside the datapath. Drives the pipeline-register enables and flushes and the Execute-stage forwarding muxes.

Parameters:
- NRP, 3, number of register read ports checked (RA1, RA2, RA3).
- AW, 4, register address width.
- HOLDOFF, 4, cycles after reset release during which hazard logic is suppressed (0 = none).
- CNT_W, 16, width of the event counters.
- EXCL_R15, 1, when 1 an address of all-ones (PC) never produces a forwarding match.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra_d  in  NRP*AW  Decode read addresses; port p occupies bits [p*AW +: AW].
- ra_d_used  in  NRP  Decode port p really reads a register.
- ra_e  in  NRP*AW  Execute read addresses.
- ra_e_used  in  NRP  Execute port p really reads a register.
- wa_e, wa_m, wa_w  in  AW each  destination register in E/M/W.
- regwrite_e, regwrite_m, regwrite_w  in  1 each  register write enable in E/M/W.
- memtoreg_e  in  1  E-stage instruction is a load.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1 each  instruction in the stage writes PC.
- branch_taken_e  in  1  branch resolved taken in E.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_f, stall_d  out  1 each  hold the F and D pipeline registers.
- flush_d, flush_e  out  1 each  bubble the D and E pipeline registers.
- fwd_sel_e  out  2*NRP  per-port forward select: 00 regfile, 01 ResultW, 10 ALUResultM.
- holdoff_active  out  1  holdoff in progress.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters HOLD; holdoff counter = 0.
  - stall_cnt = flush_cnt = 0; holdoff_active = 1.
  - All combinational outputs are forced to 0.
- Holdoff FSM, states HOLD and RUN:
  - HOLD: counter increments each edge. When counter == HOLDOFF-1, the next edge moves to RUN.
  - HOLDOFF = 0: the first edge after release moves to RUN.
  - RUN stays until reset.
  - holdoff_active = (state == HOLD), registered.
- In HOLD: stall_*=0, flush_*=0, fwd_sel_e=0, counters frozen.
- Forwarding (RUN, combinational, 0-cycle latency), per port p:
  - mM = ra_e_used[p] & regwrite_m & (ra_e[p] == wa_m) & ~(EXCL_R15 & ra_e[p] == all-ones).
  - mW is the same against wa_w / regwrite_w.
  - fwd = mM ? 10 : mW ? 01 : 00. M has priority when both match.
- Load-use: ldrstall = memtoreg_e & regwrite_e & OR over p of (ra_d_used[p] & ra_d[p] == wa_e).
- PC-write pending: pcw = pcsrc_d | pcsrc_e | pcsrc_m.
- Stall and flush outputs:
  - stall_d = ldrstall.
  - stall_f = ldrstall | pcw.
  - flush_d = pcw | pcsrc_w | branch_taken_e.
  - flush_e = ldrstall | branch_taken_e.
  - When ldrstall and branch_taken_e are both high, both stalls and both flushes assert together.
- Counters (RUN only):
  - stall_cnt += 1 on each cycle with stall_f.
  - flush_cnt += 1 on each cycle with flush_d | flush_e (one count per cycle, not per signal).
  - Both saturate at 2^CNT_W-1; they do not wrap.
  - cnt_clr takes priority over a simultaneous increment; the counter reads 0 next cycle.
- Reset asserted mid-operation: immediate return to HOLD, counters cleared, outputs zeroed.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - holdoff_state_t enum {HOLD, RUN};
  - constant REG_PC = all-ones.
- Sub-module hazard_holdoff (HOLDOFF parameter; ports clk, reset, holdoff_active): the FSM plus its counter.
- The counters and comparators stay in the top module, using a generate loop over NRP.

Test Plan:
- Holdoff: HOLDOFF=4, release reset, with regwrite_m=1, ra_e[0]=wa_m=3 → fwd_sel_e[1:0]=00 and holdoff_active=1 for 4 edges. On the 5th cycle fwd=10 and holdoff_active=0.
- Forward priority: ra_e[1]=5, wa_m=wa_w=5, both regwrites=1 → port1 sel 10. With regwrite_m=0 → 01. With ra_e_used[1]=0 → 00. With ra_e[2]=15, EXCL_R15=1 → 00.
- Load-use on RA3: memtoreg_e=1, regwrite_e=1, wa_e=7, ra_d[2]=7, ra_d_used[2]=1 → stall_f=stall_d=flush_e=1, flush_d=0, stall_cnt +1. With ra_d_used[2]=0 → all 0.
- PC write walk: pulse pcsrc through D, E, M, W on successive cycles → stall_f=1 for 3 cycles, flush_d=1 for 4 cycles; flush_cnt +4.
- Simultaneous: ldrstall=1 and branch_taken_e=1 → stall_f, stall_d, flush_d, flush_e all 1; flush_cnt +1 only.
- Counter saturation and clear: CNT_W=4, hold stall for 20 cycles → stall_cnt=15. cnt_clr with stall still high → 0 next cycle, then 1. Async reset mid-run → counters 0 and holdoff_active=1 immediately.
